// File: rtl/wb_combiner_pkg.sv
// Shared definitions for the Wishbone write combiner: state encoding,
// bus widths, the full-word lane select value and a byte-lane mask helper.
package wb_combiner_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    localparam logic [3:0] SEL_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } comb_state_t;

    // Expand four byte-lane selects into a 32-bit byte mask.
    function automatic logic [WB_DW-1:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_lane_merge.sv
// Per-byte merge of the held write word with a new partial write:
// every byte whose select is set comes from the new data, the rest
// keep the held value.
module wb_lane_merge
    import wb_combiner_pkg::*;
(
    input  logic [WB_DW-1:0] hold_dat,
    input  logic [WB_DW-1:0] new_dat,
    input  logic [3:0]       new_sel,
    output logic [WB_DW-1:0] merged_dat
);

    logic [WB_DW-1:0] mask_s;

    // Pick each byte from the new or the held word according to its select.
    always_comb begin
        mask_s     = lane_mask(new_sel);
        merged_dat = (new_dat & mask_s) | (hold_dat & ~mask_s);
    end

endmodule

// File: rtl/wb_write_combiner.sv
// Wishbone write combiner placed in front of the posted write buffer.
// Consecutive partial writes to one 32-bit word are merged in a hold
// register and leave as a single write; reads pass through only once no
// merged write is pending. Flush request/ack are forwarded so a flush
// covers both this stage and the write buffer.
// Optional feature: define WB_COMBINE_STATS_EN to enable the 16-bit
// saturating merge/drain statistics counters (otherwise they read 0).
module wb_write_combiner
    import wb_combiner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int TCNT_W         = 4
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic [WB_AW-1:0] s_adr_i,
    input  logic [WB_DW-1:0] s_dat_i,
    output logic [WB_DW-1:0] s_dat_o,
    input  logic [3:0]       s_sel_i,
    input  logic             s_cyc_i,
    input  logic             s_stb_i,
    input  logic             s_we_i,
    output logic             s_ack_o,
    output logic [WB_AW-1:0] m_adr_o,
    output logic [WB_DW-1:0] m_dat_o,
    output logic [3:0]       m_sel_o,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    input  logic [WB_DW-1:0] m_dat_i,
    input  logic             m_ack_i,
    input  logic             flushreq_i,
    output logic             flushack_o,
    output logic             flushreq_o,
    input  logic             flushack_i,
    output logic [15:0]      merge_cnt_o,
    output logic [15:0]      drain_cnt_o
);

    localparam logic [TCNT_W-1:0] TIMER_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    comb_state_t        state_r, state_s;
    logic [WB_AW-1:2]   hadr_r, hadr_s;
    logic [WB_DW-1:0]   hdat_r, hdat_s;
    logic [3:0]         hsel_r, hsel_s;
    logic [TCNT_W-1:0]  timer_r, timer_s;

    logic               req_s, wr_s, rd_s, same_word_s;
    logic [WB_DW-1:0]   merged_dat_s;
    logic [3:0]         merged_sel_s;
    logic               ack_s, mcyc_s, mwe_s;

    assign req_s        = s_cyc_i & s_stb_i;
    assign wr_s         = req_s & s_we_i;
    assign rd_s         = req_s & ~s_we_i;
    assign same_word_s  = (s_adr_i[WB_AW-1:2] == hadr_r);
    assign merged_sel_s = hsel_r | s_sel_i;

    wb_lane_merge u_lane_merge (
        .hold_dat   (hdat_r),
        .new_dat    (s_dat_i),
        .new_sel    (s_sel_i),
        .merged_dat (merged_dat_s)
    );

    // Next-state, hold register update and bus outputs of the combiner FSM.
    always_comb begin
        state_s = state_r;
        hadr_s  = hadr_r;
        hdat_s  = hdat_r;
        hsel_s  = hsel_r;
        timer_s = timer_r;
        ack_s   = 1'b0;
        mcyc_s  = 1'b0;
        mwe_s   = 1'b0;
        m_adr_o = {hadr_r, 2'b00};
        m_dat_o = hdat_r;
        m_sel_o = hsel_r;
        case (state_r)
            IDLE: begin
                if (rd_s) begin
                    // Read pass-through to the write buffer.
                    mcyc_s  = 1'b1;
                    m_adr_o = s_adr_i;
                    m_dat_o = s_dat_i;
                    m_sel_o = s_sel_i;
                    ack_s   = m_ack_i;
                end else if (wr_s && !flushreq_i) begin
                    ack_s = 1'b1;
                    if (s_sel_i != 4'h0) begin
                        hadr_s  = s_adr_i[WB_AW-1:2];
                        hdat_s  = s_dat_i;
                        hsel_s  = s_sel_i;
                        timer_s = '0;
                        state_s = (s_sel_i == SEL_FULL) ? DRAIN : HOLD;
                    end else begin
                        // A write with no lanes selected changes nothing.
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                if (flushreq_i) begin
                    state_s = DRAIN;
                end else if (wr_s && same_word_s) begin
                    ack_s   = 1'b1;
                    hdat_s  = merged_dat_s;
                    hsel_s  = merged_sel_s;
                    timer_s = '0;
                    state_s = (merged_sel_s == SEL_FULL) ? DRAIN : HOLD;
                end else if (req_s) begin
                    // Other word or a read: drain first, request waits for IDLE.
                    state_s = DRAIN;
                end else if (timer_r == TIMER_LAST) begin
                    state_s = DRAIN;
                end else begin
                    timer_s = timer_r + TCNT_W'(1);
                end
            end
            DRAIN: begin
                mcyc_s = 1'b1;
                mwe_s  = 1'b1;
                if (m_ack_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, hold register and timeout counter; reset drops any held write.
    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            state_r <= IDLE;
            hadr_r  <= '0;
            hdat_r  <= '0;
            hsel_r  <= 4'h0;
            timer_r <= '0;
        end else begin
            state_r <= state_s;
            hadr_r  <= hadr_s;
            hdat_r  <= hdat_s;
            hsel_r  <= hsel_s;
            timer_r <= timer_s;
        end
    end

    assign s_ack_o    = ack_s & ~sclr;
    assign m_cyc_o    = mcyc_s & ~sclr;
    assign m_stb_o    = mcyc_s & ~sclr;
    assign m_we_o     = mwe_s & ~sclr;
    assign s_dat_o    = m_dat_i;
    assign flushreq_o = flushreq_i;
    assign flushack_o = (state_r == IDLE) & flushack_i;

`ifdef WB_COMBINE_STATS_EN
    logic [15:0] merge_cnt_r;
    logic [15:0] drain_cnt_r;
    logic        merge_ev_s;
    logic        drain_ev_s;

    assign merge_ev_s = (state_r == HOLD) & wr_s & same_word_s & ~flushreq_i;
    assign drain_ev_s = (state_r == DRAIN) & m_ack_i;

    // Saturating merge and drain statistics counters.
    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            merge_cnt_r <= 16'd0;
            drain_cnt_r <= 16'd0;
        end else begin
            if (merge_ev_s && (merge_cnt_r != 16'hFFFF)) begin
                merge_cnt_r <= merge_cnt_r + 16'd1;
            end else begin
                merge_cnt_r <= merge_cnt_r;
            end
            if (drain_ev_s && (drain_cnt_r != 16'hFFFF)) begin
                drain_cnt_r <= drain_cnt_r + 16'd1;
            end else begin
                drain_cnt_r <= drain_cnt_r;
            end
        end
    end

    assign merge_cnt_o = merge_cnt_r;
    assign drain_cnt_o = drain_cnt_r;
`else
    assign merge_cnt_o = 16'd0;
    assign drain_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_wb_write_combiner.sv
// Self-checking bench for wb_write_combiner. A transaction-level model
// (one pending merged word, its drain deadline, committed memory image)
// is updated from observed upstream acceptances and checked against the
// downstream bus every cycle. Directed cases pin the model with literals,
// then a randomized phase exercises merging, timeouts, reads and flushes.
module tb_wb_write_combiner;

    localparam int T = 8;
`ifdef WB_COMBINE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clock;
    logic        sclr;
    logic [31:0] s_adr_i, s_dat_i, s_dat_o;
    logic [3:0]  s_sel_i;
    logic        s_cyc_i, s_stb_i, s_we_i, s_ack_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
    logic        flushreq_i, flushack_o, flushreq_o, flushack_i;
    logic [15:0] merge_cnt_o, drain_cnt_o;

    wb_write_combiner #(.TIMEOUT_CYCLES(T), .TCNT_W(4)) dut (
        .clock(clock), .sclr(sclr),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_sel_i(s_sel_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .flushreq_i(flushreq_i), .flushack_o(flushack_o),
        .flushreq_o(flushreq_o), .flushack_i(flushack_i),
        .merge_cnt_o(merge_cnt_o), .drain_cnt_o(drain_cnt_o)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // model state
    logic        pend_v, drain_on;
    logic [29:0] pend_adr;
    logic [31:0] pend_dat;
    logic [3:0]  pend_sel;
    int          pend_last, pend_dead;
    int          n_merge, n_drain, last_lat;
    logic [31:0] last_w_adr, last_w_dat;
    logic [3:0]  last_w_sel;
    logic [31:0] cmem [256];

    // slave state
    logic [31:0] smem [256];
    int          ack_dly;
    bit          ack_rand;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Downstream write buffer: memory with a per-transaction ack delay.
    initial begin
        int wcnt;
        int cur_dly;
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        flushack_i = 1'b0;
        wcnt = 0;
        cur_dly = 1;
        for (int i = 0; i < 256; i++) smem[i] = 32'd0;
        forever begin
            @(posedge clock);
            #2;
            flushack_i = 1'($urandom_range(0, 1));
            if (sclr || m_ack_i) begin
                m_ack_i = 1'b0;
                wcnt = 0;
                cur_dly = ack_rand ? int'($urandom_range(0, 2)) : ack_dly;
            end else if (m_cyc_o && m_stb_o) begin
                if (wcnt >= cur_dly) begin
                    m_ack_i = 1'b1;
                    if (m_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (m_sel_o[b]) smem[m_adr_o[9:2]][8*b +: 8] = m_dat_o[8*b +: 8];
                    end
                    m_dat_i = smem[m_adr_o[9:2]];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                cur_dly = ack_rand ? int'($urandom_range(0, 2)) : ack_dly;
            end
        end
    end

    // Model update and per-cycle comparison, sampled on the falling edge.
    initial begin
        logic        wact;
        logic [31:0] exp_mc, exp_dc;
        pend_v = 1'b0; drain_on = 1'b0; n_merge = 0; n_drain = 0; last_lat = 0;
        pend_adr = 30'd0; pend_dat = 32'd0; pend_sel = 4'd0; pend_last = 0; pend_dead = 0;
        last_w_adr = 32'd0; last_w_dat = 32'd0; last_w_sel = 4'd0;
        for (int i = 0; i < 256; i++) cmem[i] = 32'd0;
        forever begin
            @(negedge clock);
            if (sclr) begin
                pend_v = 1'b0; drain_on = 1'b0; n_merge = 0; n_drain = 0;
                chk("rst_m_cyc", 32'(m_cyc_o), 32'd0);
                chk("rst_s_ack", 32'(s_ack_o), 32'd0);
            end else begin
                exp_mc = STATS_ON ? 32'(n_merge) : 32'd0;
                exp_dc = STATS_ON ? 32'(n_drain) : 32'd0;
                chk("merge_cnt", 32'(merge_cnt_o), exp_mc);
                chk("drain_cnt", 32'(drain_cnt_o), exp_dc);
                chk("flushack", 32'(flushack_o), 32'(flushack_i & ~pend_v));
                chk("flushreq_fwd", 32'(flushreq_o), 32'(flushreq_i));
                if (m_cyc_o && !m_we_o) chk("read_behind_write", 32'(pend_v), 32'd0);
                wact = m_cyc_o & m_stb_o & m_we_o;
                if (wact || (pend_v && drain_on)) begin
                    chk("drain_active", 32'(wact), 32'd1);
                    chk("drain_expected", 32'(pend_v), 32'd1);
                    if (wact && pend_v) begin
                        if (!drain_on) begin
                            drain_on = 1'b1;
                            last_lat = cyc - pend_last;
                            chk("drain_start_cycle", 32'(cyc), 32'(pend_dead + 1));
                        end
                        chk("drain_adr", m_adr_o, {pend_adr, 2'b00});
                        chk("drain_dat", m_dat_o, pend_dat);
                        chk("drain_sel", 32'(m_sel_o), 32'(pend_sel));
                        if (m_ack_i) begin
                            for (int b = 0; b < 4; b++)
                                if (pend_sel[b]) cmem[pend_adr[7:0]][8*b +: 8] = pend_dat[8*b +: 8];
                            last_w_adr = {pend_adr, 2'b00};
                            last_w_dat = pend_dat;
                            last_w_sel = pend_sel;
                            n_drain++;
                            pend_v = 1'b0;
                            drain_on = 1'b0;
                        end
                    end
                end
                if (pend_v && !drain_on && !s_ack_o && ((s_cyc_i && s_stb_i) || flushreq_i)) begin
                    if (cyc < pend_dead) pend_dead = cyc;
                end
                if (s_cyc_i && s_stb_i && s_ack_o) begin
                    if (s_we_i) begin
                        chk("write_during_flush", 32'(flushreq_i), 32'd0);
                        if (pend_v && !drain_on && s_adr_i[31:2] == pend_adr && cyc <= pend_dead) begin
                            for (int b = 0; b < 4; b++)
                                if (s_sel_i[b]) pend_dat[8*b +: 8] = s_dat_i[8*b +: 8];
                            pend_sel = pend_sel | s_sel_i;
                            pend_last = cyc;
                            pend_dead = (pend_sel == 4'hF) ? cyc : cyc + T;
                            n_merge++;
                        end else begin
                            chk("write_order", 32'(pend_v), 32'd0);
                            pend_v = 1'b1;
                            drain_on = 1'b0;
                            pend_adr = s_adr_i[31:2];
                            pend_dat = s_dat_i;
                            pend_sel = s_sel_i;
                            pend_last = cyc;
                            pend_dead = (s_sel_i == 4'hF) ? cyc : cyc + T;
                        end
                    end else begin
                        chk("read_order", 32'(pend_v), 32'd0);
                        chk("read_data", s_dat_o, cmem[s_adr_i[9:2]]);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic got;
        got = 1'b0;
        s_adr_i = a; s_dat_i = d; s_sel_i = s;
        s_we_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clock);
            got = s_ack_o;
        end
        chk("wr_ack_wait", 32'(got), 32'd1);
        @(posedge clock);
        #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d = 32'd0;
        s_adr_i = a; s_sel_i = 4'hF;
        s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clock);
            got = s_ack_o;
            d = s_dat_o;
        end
        chk("rd_ack_wait", 32'(got), 32'd1);
        @(posedge clock);
        #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
    endtask

    task automatic wait_drains(input int target);
        for (int k = 0; k < 200 && n_drain < target; k++) @(negedge clock);
        chk("drain_wait", 32'(n_drain), 32'(target));
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        int base;
        int gap;
        sclr = 1'b1;
        s_adr_i = 32'd0; s_dat_i = 32'd0; s_sel_i = 4'd0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        flushreq_i = 1'b0;
        ack_dly = 1; ack_rand = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_m_cyc", 32'(m_cyc_o), 32'd0);
        chk("reset_s_ack", 32'(s_ack_o), 32'd0);
        chk("reset_flushack", 32'(flushack_o), 32'(flushack_i));
        chk("reset_merge_cnt", 32'(merge_cnt_o), 32'd0);
        chk("reset_drain_cnt", 32'(drain_cnt_o), 32'd0);
        #1 sclr = 1'b0;
        @(posedge clock);
        #1;

        // byte writes merge into one full word
        base = n_drain;
        wr(32'h100, 32'hDEADBE11, 4'h1);
        wr(32'h100, 32'h5A5A225A, 4'h2);
        wr(32'h100, 32'hA533A5A5, 4'h4);
        wr(32'h100, 32'h44C3C3C3, 4'h8);
        wait_drains(base + 1);
        chk("t1_adr", last_w_adr, 32'h100);
        chk("t1_dat", last_w_dat, 32'h44332211);
        chk("t1_sel", 32'(last_w_sel), 32'hF);
        chk("t1_model_merges", 32'(n_merge), 32'd3);
        chk("t1_merge_cnt", 32'(merge_cnt_o), STATS_ON ? 32'd3 : 32'd0);

        // lone partial write drains on timeout
        base = n_drain;
        wr(32'h104, 32'h0000AA00, 4'h2);
        wait_drains(base + 1);
        chk("t2_latency", 32'(last_lat), 32'(T + 1));
        chk("t2_dat", last_w_dat, 32'h0000AA00);
        chk("t2_sel", 32'(last_w_sel), 32'h2);

        // write to another word forces the held one out first
        base = n_drain;
        wr(32'h200, 32'h000000C3, 4'h1);
        wr(32'h204, 32'h000000D4, 4'h1);
        chk("t3_first_drained", 32'(n_drain - base), 32'd1);
        chk("t3_first_adr", last_w_adr, 32'h200);
        wait_drains(base + 2);
        chk("t3_second_adr", last_w_adr, 32'h204);

        // read behind a held write sees the merged data
        base = n_drain;
        wr(32'h300, 32'h0000BEEF, 4'h3);
        rd(32'h300, d);
        chk("t4_read", d, 32'h0000BEEF);
        chk("t4_drained_before_read", 32'(n_drain - base), 32'd1);

        // flush forces an immediate drain and holds off new writes
        base = n_drain;
        wr(32'h108, 32'h00000077, 4'h1);
        flushreq_i = 1'b1;
        s_adr_i = 32'h10C; s_dat_i = 32'h12345678; s_sel_i = 4'hF;
        s_we_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        repeat (T + 6) begin
            @(negedge clock);
            chk("t5_held_off", 32'(s_ack_o), 32'd0);
        end
        chk("t5_drained", 32'(n_drain - base), 32'd1);
        chk("t5_latency", 32'(last_lat), 32'd2);
        @(posedge clock);
        #1;
        flushreq_i = 1'b0;
        wr(32'h10C, 32'h12345678, 4'hF);
        wait_drains(base + 2);

        // reset during a drain abandons it immediately
        ack_dly = 6;
        wr(32'h10C, 32'hCAFEF00D, 4'hF);
        #2;
        chk("t6_draining", 32'(m_cyc_o), 32'd1);
        sclr = 1'b1;
        #1;
        chk("t6_m_cyc_dropped", 32'(m_cyc_o), 32'd0);
        chk("t6_merge_cnt", 32'(merge_cnt_o), 32'd0);
        chk("t6_drain_cnt", 32'(drain_cnt_o), 32'd0);
        @(negedge clock);
        @(posedge clock);
        #2 sclr = 1'b0;
        @(posedge clock);
        #1;
        ack_dly = 1;
        chk("t6_idle_flushack", 32'(flushack_o), 32'(flushack_i));
        rd(32'h10C, d);
        chk("t6_held_data_lost", d, 32'h12345678);

        // randomized phase
        ack_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rd(32'h100 + 32'($urandom_range(0, 3)) * 32'd4, d);
            end else begin
                wr(32'h100 + 32'($urandom_range(0, 3)) * 32'd4, $urandom, 4'($urandom_range(1, 15)));
            end
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 2)) : 0;
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            if ($urandom_range(0, 15) == 0) begin
                flushreq_i = 1'b1;
                @(posedge clock);
                #1;
                flushreq_i = 1'b0;
            end
        end
        for (int k = 0; k < 100 && pend_v; k++) @(negedge clock);
        chk("final_idle", 32'(pend_v), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
